// File: rtl/keypad_pkg.sv
// Shared types, sizes and the column-priority helper for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } scan_state_t;

  // Lowest set column wins; an all-zero input maps to column 0.
  function automatic logic [1:0] lowest_col(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    if (c[0])      idx = 2'd0;
    else if (c[1]) idx = 2'd1;
    else if (c[2]) idx = 2'd2;
    else if (c[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, reset to zero.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner_4x4.sv
// Row scanner for a 4x4 matrix keypad: drives a 2:4 row decoder, samples the
// synchronised columns once per row dwell, debounces and reports one code per press.
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 8,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [1:0] row_sel,
  output logic       row_en,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TGT    = CW'(DEBOUNCE);

  logic [3:0]       w_col_s;
  logic             w_sample;
  logic [1:0]       w_low;
  logic             w_any;

  logic [DW-1:0]    r_dwell;
  logic [1:0]       r_row;
  scan_state_t      r_state;
  logic [1:0]       r_cand_col;
  logic [CW-1:0]    r_match;
  logic [CW-1:0]    r_rel;
  logic [KEY_W-1:0] r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  sync_2ff #(.WIDTH(COLS)) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (col),
    .o_q   (w_col_s)
  );

  assign w_sample = (r_dwell == DWELL_LAST);
  assign w_low    = lowest_col(w_col_s);
  assign w_any    = |w_col_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
    end else if (w_sample) begin
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // The row only moves on a sample edge, so it changes exactly as dwell wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row       <= 2'd0;
      r_state     <= ST_SCAN;
      r_cand_col  <= 2'd0;
      r_match     <= '0;
      r_rel       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_sample) begin
        case (r_state)
          ST_SCAN: begin
            if (w_any) begin
              r_cand_col <= w_low;
              if (DEBOUNCE == 1) begin
                r_key_code  <= {r_row, w_low};
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_rel       <= '0;
                r_state     <= ST_PRESSED;
              end else begin
                r_match <= CW'(1);
                r_state <= ST_DEBOUNCE;
              end
            end else begin
              r_row <= r_row + 2'd1;
            end
          end
          ST_DEBOUNCE: begin
            if (w_any && (w_low == r_cand_col)) begin
              if ((r_match + CW'(1)) == CNT_TGT) begin
                r_key_code  <= {r_row, r_cand_col};
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_rel       <= '0;
                r_state     <= ST_PRESSED;
              end else begin
                r_match <= r_match + CW'(1);
              end
            end else begin
              r_row   <= r_row + 2'd1;
              r_state <= ST_SCAN;
            end
          end
          ST_PRESSED: begin
            // Only the accepted key's column matters; other keys are ignored.
            if (!w_col_s[r_cand_col]) begin
              if ((r_rel + CW'(1)) == CNT_TGT) begin
                r_key_held <= 1'b0;
                r_rel      <= '0;
                r_row      <= r_row + 2'd1;
                r_state    <= ST_SCAN;
              end else begin
                r_rel <= r_rel + CW'(1);
              end
            end else begin
              r_rel <= '0;
            end
          end
          default: begin
            r_state <= ST_SCAN;
          end
        endcase
      end
    end
  end

  // Break-before-make: the decoder is disabled during the dwell-0 cycle.
  assign row_en    = (r_dwell != '0);
  assign row_sel   = r_row;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Directed bench for keypad_scanner_4x4 with a simple keypad model driving the columns.
module tb_keypad_scanner_4x4;

  logic       clk;
  logic       rst_n;
  logic [3:0] col;
  logic [1:0] row_sel;
  logic       row_en;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int errors = 0;
  int checks = 0;
  int cyc;
  int vcount = 0;

  // Keypad model: a pressed key connects its row line to its column(s).
  logic       kp_pressed;
  logic [1:0] kp_row;
  logic [3:0] kp_mask;

  assign col = (kp_pressed && row_en && (row_sel == kp_row)) ? kp_mask : 4'b0000;

  keypad_scanner_4x4 #(.SCAN_DIV(8), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row_sel   (row_sel),
    .row_en    (row_en),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; at a negedge cyc equals the edge count k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (key_valid) vcount = vcount + 1;
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard = guard + 1;
    end
    if (guard >= 5000) check("timeout", 8'(guard), 8'd0);
  endtask

  task automatic press(input logic [1:0] r, input logic [3:0] m);
    kp_row     = r;
    kp_mask    = m;
    kp_pressed = 1'b1;
  endtask

  initial begin
    kp_pressed = 1'b0;
    kp_row     = 2'd0;
    kp_mask    = 4'd0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_row_sel", 8'(row_sel), 8'd0);
    check("rst_row_en", 8'(row_en), 8'd0);
    check("rst_key_code", 8'(key_code), 8'd0);
    check("rst_key_valid", 8'(key_valid), 8'd0);
    check("rst_key_held", 8'(key_held), 8'd0);
    rst_n = 1'b1;

    // 1: idle scan, row advances every 8 edges, enable low on dwell 0
    for (int k = 1; k <= 64; k++) begin
      wait_cyc(k);
      check("idle_row_sel", 8'(row_sel), 8'((k / 8) % 4));
      check("idle_row_en", 8'(row_en), 8'((k % 8) != 0));
    end
    check("idle_no_valid", 8'(vcount), 8'd0);

    // 2: key on row 2 col 1; first sample at edge 88, accepted at 104
    press(2'd2, 4'b0010);
    wait_cyc(95);
    check("hold_row_sel", 8'(row_sel), 8'd2);
    wait_cyc(103);
    check("pre_valid", 8'(key_valid), 8'd0);
    wait_cyc(104);
    check("acc_valid", 8'(key_valid), 8'd1);
    check("acc_code", 8'(key_code), 8'd9);
    check("acc_held", 8'(key_held), 8'd1);
    wait_cyc(105);
    check("pulse_end", 8'(key_valid), 8'd0);
    check("held_on", 8'(key_held), 8'd1);
    wait_cyc(140);
    check("one_pulse", 8'(vcount), 8'd1);

    // 5: release; zero samples at 144, 152, 160
    kp_pressed = 1'b0;
    wait_cyc(159);
    check("rel_held_still", 8'(key_held), 8'd1);
    check("rel_row_held", 8'(row_sel), 8'd2);
    wait_cyc(160);
    check("rel_held_low", 8'(key_held), 8'd0);
    check("rel_next_row", 8'(row_sel), 8'd3);
    check("rel_en_low", 8'(row_en), 8'd0);
    check("rel_code_kept", 8'(key_code), 8'd9);
    press(2'd2, 4'b0010);
    wait_cyc(208);
    check("repress_valid", 8'(key_valid), 8'd1);
    check("repress_code", 8'(key_code), 8'd9);
    wait_cyc(215);
    check("two_pulses", 8'(vcount), 8'd2);

    // 6: asynchronous reset in PRESSED
    rst_n = 1'b0;
    #1;
    check("arst_held", 8'(key_held), 8'd0);
    check("arst_code", 8'(key_code), 8'd0);
    check("arst_row_sel", 8'(row_sel), 8'd0);
    check("arst_row_en", 8'(row_en), 8'd0);
    check("arst_valid", 8'(key_valid), 8'd0);
    kp_pressed = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(1);
    check("restart_row0", 8'(row_sel), 8'd0);
    check("restart_en", 8'(row_en), 8'd1);
    wait_cyc(8);
    check("restart_row1", 8'(row_sel), 8'd1);
    check("restart_en0", 8'(row_en), 8'd0);

    // 3: bounce on row 2; good samples at 24 and 32, zero at 40
    press(2'd2, 4'b0010);
    wait_cyc(34);
    kp_pressed = 1'b0;
    wait_cyc(39);
    check("bounce_row_held", 8'(row_sel), 8'd2);
    wait_cyc(40);
    check("bounce_row3", 8'(row_sel), 8'd3);
    wait_cyc(45);
    check("bounce_no_valid", 8'(vcount), 8'd2);

    // 4: two columns on row 1, lowest (col 1) wins; samples 64, 72, 80
    wait_cyc(50);
    press(2'd1, 4'b1010);
    wait_cyc(79);
    check("multi_pre_code", 8'(key_code), 8'd0);
    wait_cyc(80);
    check("multi_valid", 8'(key_valid), 8'd1);
    check("multi_code", 8'(key_code), 8'd5);
    check("multi_held", 8'(key_held), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
